// File: rtl/reimu_life.sv
// Player-life manager: turns boss/enemy hits into life loss with a post-hit
// invincibility window, renderer blink flag, hit strobe and sticky game-over.
module reimu_life #(
    parameter int unsigned INIT_LIVES = 3,
    parameter int unsigned MAX_LIVES  = 7,
    parameter int unsigned INV_TICKS  = 48,
    parameter int unsigned BLINK_BIT  = 2
) (
    input  logic       clk22,
    input  logic       rst,
    input  logic       gamestart,
    input  logic       shot,
    input  logic       enemy_shot,
    input  logic       extend,
    output logic [2:0] lives,
    output logic       invincible,
    output logic       blink,
    output logic       hit_pulse,
    output logic       gameover,
    output logic [7:0] hit_count
);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        INVUL = 2'd1,
        OVER  = 2'd2
    } state_t;

    localparam logic [2:0] INIT_L   = 3'(INIT_LIVES);
    localparam logic [2:0] MAX_L    = 3'(MAX_LIVES);
    localparam logic [7:0] INV_LAST = 8'(INV_TICKS - 1);

    state_t     state;
    logic [7:0] inv_cnt;
    logic [7:0] inv_dec;
    logic [7:0] count_inc;
    logic [2:0] lives_ext;
    logic [2:0] lives_hit;
    logic       hit;

    assign hit       = shot | enemy_shot;
    assign inv_dec   = inv_cnt - 8'd1;
    assign count_inc = (hit_count == 8'hFF) ? hit_count : hit_count + 8'd1;
    assign lives_ext = (lives >= MAX_L) ? MAX_L : lives + 3'd1;
    // Never underflows: the lives==1 without extend case goes to OVER instead.
    assign lives_hit = lives + {2'b00, extend} - 3'd1;

    // NOTE: every state register is assigned with <= so all updates see the
    // values from before this edge, regardless of statement order.
    always_ff @(posedge clk22) begin
        if (rst || gamestart) begin
            state      <= PLAY;
            lives      <= INIT_L;
            inv_cnt    <= 8'd0;
            invincible <= 1'b0;
            blink      <= 1'b0;
            hit_pulse  <= 1'b0;
            gameover   <= 1'b0;
            hit_count  <= 8'd0;
        end else begin
            hit_pulse <= 1'b0;
            case (state)
                PLAY: begin
                    if (hit && lives == 3'd1 && !extend) begin
                        state     <= OVER;
                        lives     <= 3'd0;
                        gameover  <= 1'b1;
                        hit_pulse <= 1'b1;
                        hit_count <= count_inc;
                    end else if (hit) begin
                        state      <= INVUL;
                        lives      <= lives_hit;
                        inv_cnt    <= INV_LAST;
                        invincible <= 1'b1;
                        blink      <= INV_LAST[BLINK_BIT];
                        hit_pulse  <= 1'b1;
                        hit_count  <= count_inc;
                    end else if (extend) begin
                        lives <= lives_ext;
                    end
                end
                INVUL: begin
                    if (extend) begin
                        lives <= lives_ext;
                    end
                    // Blink follows the counter value registered on this same edge.
                    if (inv_cnt != 8'd0) begin
                        inv_cnt <= inv_dec;
                        blink   <= inv_dec[BLINK_BIT];
                    end else begin
                        state      <= PLAY;
                        invincible <= 1'b0;
                        blink      <= 1'b0;
                    end
                end
                OVER: begin
                    lives    <= 3'd0;
                    gameover <= 1'b1;
                end
                default: begin
                    state <= PLAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reimu_life.sv
// Self-checking bench for reimu_life: a directed vector table followed by
// hand-written multi-cycle sequences (invincibility window, held shot, game over).
module tb_reimu_life;

    logic       clk22 = 1'b0;
    logic       rst = 1'b0;
    logic       gamestart = 1'b0;
    logic       shot = 1'b0;
    logic       enemy_shot = 1'b0;
    logic       extend = 1'b0;
    logic [2:0] lives;
    logic       invincible;
    logic       blink;
    logic       hit_pulse;
    logic       gameover;
    logic [7:0] hit_count;

    int tests = 0;
    int failed = 0;

    reimu_life dut (
        .clk22      (clk22),
        .rst        (rst),
        .gamestart  (gamestart),
        .shot       (shot),
        .enemy_shot (enemy_shot),
        .extend     (extend),
        .lives      (lives),
        .invincible (invincible),
        .blink      (blink),
        .hit_pulse  (hit_pulse),
        .gameover   (gameover),
        .hit_count  (hit_count)
    );

    always #5 clk22 = ~clk22;

    typedef struct {
        logic       rst;
        logic       gs;
        logic       shot;
        logic       eshot;
        logic       ext;
        logic [2:0] lives;
        logic       inv;
        logic       blink;
        logic       pulse;
        logic       over;
        logic [7:0] count;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk22);
        #1;
    endtask

    task automatic drive(input logic r, input logic g, input logic s, input logic e, input logic x);
        rst = r; gamestart = g; shot = s; enemy_shot = e; extend = x;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic single_hit();
        drive(0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        int n;
        int blink_err;
        int pulses;
        int first_idx;
        int second_idx;
        logic exp_blink;
        logic [7:0] cnt_model;

        //            rst gs sh es ex  lives inv blk pls ovr count
        vecs[0]  = '{1, 0, 0, 0, 0, 3'd3, 0, 0, 0, 0, 8'd0};  // reset
        vecs[1]  = '{0, 0, 0, 0, 1, 3'd4, 0, 0, 0, 0, 8'd0};  // extend
        vecs[2]  = '{0, 0, 0, 0, 1, 3'd5, 0, 0, 0, 0, 8'd0};
        vecs[3]  = '{0, 0, 0, 0, 1, 3'd6, 0, 0, 0, 0, 8'd0};
        vecs[4]  = '{0, 0, 0, 0, 1, 3'd7, 0, 0, 0, 0, 8'd0};
        vecs[5]  = '{0, 0, 0, 0, 1, 3'd7, 0, 0, 0, 0, 8'd0};  // saturate at 7
        vecs[6]  = '{0, 0, 1, 1, 0, 3'd6, 1, 1, 1, 0, 8'd1};  // both hit lines = one hit, cnt 47
        vecs[7]  = '{0, 0, 0, 0, 0, 3'd6, 1, 1, 0, 0, 8'd1};  // cnt 46
        vecs[8]  = '{0, 0, 1, 0, 0, 3'd6, 1, 1, 0, 0, 8'd1};  // hit ignored, cnt 45
        vecs[9]  = '{0, 0, 0, 0, 1, 3'd7, 1, 1, 0, 0, 8'd1};  // extend in INVUL, cnt 44
        vecs[10] = '{0, 1, 1, 0, 1, 3'd3, 0, 0, 0, 0, 8'd0};  // gamestart overrides
        vecs[11] = '{0, 0, 0, 0, 0, 3'd3, 0, 0, 0, 0, 8'd0};
        vecs[12] = '{0, 0, 1, 0, 1, 3'd3, 1, 1, 1, 0, 8'd1};  // hit + extend: 3-1+1
        vecs[13] = '{1, 0, 0, 0, 0, 3'd3, 0, 0, 0, 0, 8'd0};  // reset mid-INVUL

        tick();
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rst, vecs[i].gs, vecs[i].shot, vecs[i].eshot, vecs[i].ext);
            tick();
            check($sformatf("vec%0d lives", i), 32'(lives), 32'(vecs[i].lives));
            check($sformatf("vec%0d invincible", i), 32'(invincible), 32'(vecs[i].inv));
            check($sformatf("vec%0d blink", i), 32'(blink), 32'(vecs[i].blink));
            check($sformatf("vec%0d hit_pulse", i), 32'(hit_pulse), 32'(vecs[i].pulse));
            check($sformatf("vec%0d gameover", i), 32'(gameover), 32'(vecs[i].over));
            check($sformatf("vec%0d hit_count", i), 32'(hit_count), 32'(vecs[i].count));
        end
        drive(0, 0, 0, 0, 0);

        // Single shot: 48-cycle window, blink follows bit 2 of the countdown.
        do_reset();
        single_hit();
        check("single lives", 32'(lives), 32'd2);
        check("single pulse", 32'(hit_pulse), 32'd1);
        check("single count", 32'(hit_count), 32'd1);
        n = 0;
        blink_err = 0;
        while (invincible === 1'b1 && n < 100) begin
            cnt_model = 8'(47 - n);
            exp_blink = cnt_model[2];
            if (blink !== exp_blink) blink_err++;
            if (n > 0 && hit_pulse !== 1'b0) blink_err++;
            n++;
            tick();
        end
        check("single window length", 32'(n), 32'd48);
        check("single blink/pulse errors", 32'(blink_err), 32'd0);
        check("single blink after window", 32'(blink), 32'd0);

        // Shot held for 90 edges: accepted at edge 0 and again at edge 49
        // (first PLAY cycle after the 48-cycle window).
        do_reset();
        pulses = 0;
        first_idx = -1;
        second_idx = -1;
        drive(0, 0, 1, 0, 0);
        for (int k = 0; k < 90; k++) begin
            tick();
            if (hit_pulse === 1'b1) begin
                if (pulses == 0) first_idx = k;
                else if (pulses == 1) second_idx = k;
                pulses++;
            end
        end
        drive(0, 0, 0, 0, 0);
        check("held pulses", 32'(pulses), 32'd2);
        check("held first edge", 32'(first_idx), 32'd0);
        check("held second edge", 32'(second_idx), 32'd49);
        check("held lives", 32'(lives), 32'd1);
        check("held count", 32'(hit_count), 32'd2);

        // lives == 1 with shot and extend on the same edge: stays 1, INVUL.
        idle(60);
        drive(0, 0, 1, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        check("last life+extend lives", 32'(lives), 32'd1);
        check("last life+extend invincible", 32'(invincible), 32'd1);
        check("last life+extend gameover", 32'(gameover), 32'd0);
        check("last life+extend count", 32'(hit_count), 32'd3);

        // Three spaced hits to game over, then everything is ignored.
        do_reset();
        single_hit();
        idle(60);
        single_hit();
        idle(60);
        check("pre-over lives", 32'(lives), 32'd1);
        single_hit();
        check("over lives", 32'(lives), 32'd0);
        check("over gameover", 32'(gameover), 32'd1);
        check("over pulse", 32'(hit_pulse), 32'd1);
        check("over invincible", 32'(invincible), 32'd0);
        drive(0, 0, 1, 1, 1);
        repeat (5) tick();
        check("over absorb lives", 32'(lives), 32'd0);
        check("over absorb count", 32'(hit_count), 32'd3);
        check("over absorb gameover", 32'(gameover), 32'd1);
        check("over absorb pulse", 32'(hit_pulse), 32'd0);
        drive(0, 1, 0, 0, 0);
        tick();
        check("gamestart lives", 32'(lives), 32'd3);
        check("gamestart gameover", 32'(gameover), 32'd0);
        check("gamestart count", 32'(hit_count), 32'd0);
        drive(0, 0, 0, 0, 0);

        // rst 10 cycles into INVUL; the window must not resume.
        single_hit();
        idle(10);
        check("mid-invul invincible", 32'(invincible), 32'd1);
        do_reset();
        check("mid-invul rst lives", 32'(lives), 32'd3);
        check("mid-invul rst invincible", 32'(invincible), 32'd0);
        check("mid-invul rst count", 32'(hit_count), 32'd0);
        idle(3);
        check("mid-invul no resume", 32'(invincible), 32'd0);
        check("mid-invul no resume blink", 32'(blink), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
